// File: rtl/nn_pkg.sv
// nn_pkg: shared state encoding and data width for the inference sequencer
package nn_pkg;
  localparam int DW = 8;
  typedef enum logic [2:0] {IDLE, NRST, LOAD, FILL, RUN, COLLECT, OUT, ERR} state_t;
endpackage

// File: rtl/nn_seq_buf.sv
// nn_seq_buf: single-write-port buffer with registered, enable-gated read
module nn_seq_buf import nn_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input logic clk,
  input logic we,
  input logic [AW-1:0] waddr,
  input logic signed [DW-1:0] wdata,
  input logic re,
  input logic [AW-1:0] raddr,
  output logic signed [DW-1:0] rdata
);
  logic signed [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/nn_sequencer.sv
// nn_sequencer: drives one host-to-network inference with a per-phase timeout
module nn_sequencer import nn_pkg::*; #(
  parameter int N_IN = 2,
  parameter int N_OUT = 1,
  parameter int TMO = 255,
  localparam int IAW = N_IN > 1 ? $clog2(N_IN) : 1,
  localparam int OAW = N_OUT > 1 ? $clog2(N_OUT) : 1,
  localparam int ICW = $clog2(N_IN) + 1,
  localparam int OCW = $clog2(N_OUT) + 1,
  localparam int TW = $clog2(TMO + 1)
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic in_valid,
  output logic in_ready,
  input logic signed [DW-1:0] in_data,
  output logic net_rst,
  output logic net_fill,
  input logic net_rd,
  input logic [IAW-1:0] net_rd_addr,
  output logic signed [DW-1:0] net_din,
  input logic net_ack_fill,
  output logic net_req,
  input logic net_ack,
  input logic net_out_valid,
  input logic signed [DW-1:0] net_out_data,
  output logic res_valid,
  input logic res_ready,
  output logic signed [DW-1:0] res_data,
  output logic busy,
  output logic done,
  output logic err
);
  state_t state;
  logic [ICW-1:0] icnt;
  logic [OCW-1:0] ocnt, rcnt, rnext;
  logic [TW-1:0] tmr;
  logic in_fire, out_fire, rc_adv, phase_tmo;
  always_comb begin
    in_fire = state == LOAD && in_valid && in_ready;
    out_fire = (state == RUN || state == COLLECT) && net_out_valid && ocnt != OCW'(N_OUT);
    rc_adv = state == OUT && res_ready;
    phase_tmo = tmr == TW'(TMO - 1) && ((state == FILL && !net_ack_fill) || (state == RUN && !net_ack) ||
                (state == COLLECT && ocnt != OCW'(N_OUT)));
    rnext = state != OUT || (rc_adv && rcnt == OCW'(N_OUT - 1)) ? '0 : rcnt + OCW'(rc_adv);
  end
  nn_seq_buf #(.DEPTH(N_IN)) ibuf (
    .clk(clk), .we(in_fire), .waddr(icnt[IAW-1:0]), .wdata(in_data),
    .re(net_rd), .raddr(net_rd_addr), .rdata(net_din)
  );
  // Read address runs one beat ahead so res_data is already registered when res_valid rises
  nn_seq_buf #(.DEPTH(N_OUT)) obuf (
    .clk(clk), .we(out_fire), .waddr(ocnt[OAW-1:0]), .wdata(net_out_data),
    .re(1'b1), .raddr(rnext[OAW-1:0]), .rdata(res_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      icnt <= '0;
      ocnt <= '0;
      rcnt <= '0;
      tmr <= '0;
      err <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      in_ready <= 1'b0;
      net_fill <= 1'b0;
      net_req <= 1'b0;
      res_valid <= 1'b0;
      net_rst <= 1'b1;
    end else begin
      done <= 1'b0;
      rcnt <= rnext;
      if (state inside {NRST, FILL, RUN, COLLECT}) tmr <= tmr + TW'(1);
      if (in_fire) icnt <= icnt + ICW'(1);
      if (out_fire) ocnt <= ocnt + OCW'(1);
      case (state)
        IDLE: begin
          net_rst <= start;
          if (start) begin
            state <= NRST;
            busy <= 1'b1;
            err <= 1'b0;
            icnt <= '0;
            ocnt <= '0;
            tmr <= '0;
          end
        end
        NRST: if (tmr == TW'(1)) begin
          state <= LOAD;
          net_rst <= 1'b0;
          in_ready <= 1'b1;
        end
        LOAD: if (in_fire && icnt == ICW'(N_IN - 1)) begin
          state <= FILL;
          in_ready <= 1'b0;
          net_fill <= 1'b1;
          tmr <= '0;
        end
        FILL: if (net_ack_fill) begin
          state <= RUN;
          net_fill <= 1'b0;
          net_req <= 1'b1;
          tmr <= '0;
        end
        RUN: if (net_ack) begin
          state <= COLLECT;
          net_req <= 1'b0;
          tmr <= '0;
        end
        COLLECT: if (ocnt == OCW'(N_OUT)) begin
          state <= OUT;
          res_valid <= 1'b1;
        end
        OUT: if (rc_adv && rcnt == OCW'(N_OUT - 1)) begin
          state <= IDLE;
          res_valid <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
        end
        ERR: begin
          state <= IDLE;
          net_rst <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (phase_tmo) begin
        state <= ERR;
        err <= 1'b1;
        net_rst <= 1'b1;
        net_fill <= 1'b0;
        net_req <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_nn_sequencer.sv
// tb_nn_sequencer: randomized directed checks of nn_sequencer against an XOR network scoreboard
module tb_nn_sequencer;
  localparam int TMO = 255;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_ready;
  logic signed [7:0] in_data = '0;
  logic net_rst, net_fill, net_rd = 1'b0, net_ack_fill = 1'b0, net_req, net_ack = 1'b0, net_out_valid = 1'b0;
  logic [0:0] net_rd_addr = '0;
  logic signed [7:0] net_din, net_out_data = '0, res_data;
  logic res_valid, res_ready = 1'b0, busy, done, err;
  int total = 0, bad = 0;
  logic signed [7:0] exp_q[$];

  always #5 clk = ~clk;

  nn_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .net_rst(net_rst), .net_fill(net_fill), .net_rd(net_rd), .net_rd_addr(net_rd_addr), .net_din(net_din),
    .net_ack_fill(net_ack_fill), .net_req(net_req), .net_ack(net_ack), .net_out_valid(net_out_valid),
    .net_out_data(net_out_data), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_net_fill"}, net_fill, 0);
    chk({tag, "_net_req"}, net_req, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_net_rst"}, net_rst, 1);
  endtask

  task automatic begin_inf(input logic signed [7:0] x0, input logic signed [7:0] x1);
    int n = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_cleared", err, 0);
    for (int k = 0; k < 20 && !in_ready; k++) begin
      n += int'(net_rst);
      @(negedge clk);
    end
    chk("load_ready", in_ready, 1);
    chk("nrst_len", n, 2);
    for (int i = 0; i < 2; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      chk("in_ready_hold", in_ready, 1);
      in_valid = 1'b1;
      in_data = i == 0 ? x0 : x1;
      @(negedge clk);
      in_valid = 1'b0;
      in_data = 8'($urandom);
    end
    chk("in_ready_off", in_ready, 0);
    chk("fill_on", net_fill, 1);
  endtask

  task automatic do_fill(input logic signed [7:0] x0, input logic signed [7:0] x1,
                         output logic signed [7:0] g0, output logic signed [7:0] g1);
    int a;
    int first = int'($urandom_range(0, 1));
    for (int r = 0; r < 3; r++) begin
      a = r == 0 ? first : r == 1 ? 1 - first : int'($urandom_range(0, 1));
      net_rd = 1'b1;
      net_rd_addr = a[0:0];
      @(negedge clk);
      net_rd = 1'b0;
      chk("net_din", net_din, a == 1 ? x1 : x0);
      if (a == 1) g1 = net_din; else g0 = net_din;
    end
    net_ack_fill = 1'b1;
    @(negedge clk);
    net_ack_fill = 1'b0;
    chk("fill_off", net_fill, 0);
    chk("req_on", net_req, 1);
  endtask

  task automatic do_run(input logic signed [7:0] y, input int mode, input bit extra);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    chk("req_hold", net_req, 1);
    if (mode == 0) begin
      net_out_valid = 1'b1;
      net_out_data = y;
      @(negedge clk);
      net_out_valid = 1'b0;
      net_ack = 1'b1;
      @(negedge clk);
      net_ack = 1'b0;
    end else if (mode == 1) begin
      net_out_valid = 1'b1;
      net_out_data = y;
      net_ack = 1'b1;
      @(negedge clk);
      net_out_valid = 1'b0;
      net_ack = 1'b0;
    end else begin
      net_ack = 1'b1;
      @(negedge clk);
      net_ack = 1'b0;
      chk("req_off", net_req, 0);
      net_out_valid = 1'b1;
      net_out_data = y;
      @(negedge clk);
      net_out_valid = 1'b0;
    end
    if (extra) begin
      net_out_valid = 1'b1;
      net_out_data = ~y;
      @(negedge clk);
      net_out_valid = 1'b0;
    end
  endtask

  task automatic do_out(input int bp);
    logic signed [7:0] d, e;
    for (int k = 0; k < 20 && !res_valid; k++) @(negedge clk);
    chk("res_valid", res_valid, 1);
    d = res_data;
    repeat (bp) begin
      @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_data", res_data, d);
    end
    e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
    chk("res_data", res_data, e);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("done_on", done, 1);
    chk("res_valid_off", res_valid, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic infer(input logic signed [7:0] x0, input logic signed [7:0] x1,
                       input int mode, input int bp, input bit extra);
    logic signed [7:0] g0, g1;
    begin_inf(x0, x1);
    exp_q.push_back(x0 ^ x1);
    do_fill(x0, x1, g0, g1);
    do_run(g0 ^ g1, mode, extra);
    do_out(bp);
  endtask

  initial begin
    logic signed [7:0] g0, g1;
    int n;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy0", busy, 0);
    infer(8'sd1, 8'sd0, 0, 0, 1'b0);
    infer(8'sd1, 8'sd1, 1, 10, 1'b0);
    // timeout: the network never acknowledges compute
    begin_inf(8'sd5, -8'sd3);
    do_fill(8'sd5, -8'sd3, g0, g1);
    n = 0;
    for (int k = 0; k < TMO + 10 && !err; k++) begin
      n += int'(net_req);
      @(negedge clk);
    end
    chk("tmo_err", err, 1);
    chk("tmo_len", n >= TMO && n <= TMO + 1, 1);
    chk("err_net_rst", net_rst, 1);
    chk("err_req", net_req, 0);
    chk("err_fill", net_fill, 0);
    chk("err_in_ready", in_ready, 0);
    chk("err_res_valid", res_valid, 0);
    @(negedge clk);
    chk("err_idle_busy", busy, 0);
    chk("err_idle_net_rst", net_rst, 0);
    chk("err_sticky", err, 1);
    infer(8'sd0, 8'sd1, 2, 1, 1'b0);
    // reset while the network is filling
    begin_inf(8'sd7, 8'sd9);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst_fill");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_result", res_valid, 0);
    infer(8'sd3, 8'sd6, 0, 2, 1'b0);
    foreach (exp_q[i]) exp_q.delete(i);
    infer(8'sd0, 8'sd0, 0, 0, 1'b0);
    infer(8'sd0, 8'sd1, 1, 0, 1'b0);
    infer(8'sd1, 8'sd0, 2, 0, 1'b0);
    infer(8'sd1, 8'sd1, 0, 0, 1'b0);
    for (int m = 0; m < 3; m++) infer(8'($urandom), 8'($urandom), m, 1, 1'b1);
    for (int i = 0; i < 16; i++)
      infer(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
            1'($urandom_range(0, 1)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nn_sequencer.md
NN_SEQUENCER -- requirements
Module: nn_sequencer

Interface
REQ-001 SHALL have parameter N_IN, default 2, number of signed 8-bit inputs per inference.
REQ-002 SHALL have parameter N_OUT, default 1, number of signed 8-bit outputs per inference.
REQ-003 SHALL have parameter TMO, default 255, cycle budget for each network phase.
REQ-004 SHALL have ports, in order:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin one inference; sampled only in IDLE.
- in_valid  in  1 / in_ready  out  1 / in_data  in  8 signed  host input stream.
- net_rst  out  1  network reset.
- net_fill  out  1  network input-fill request.
- net_rd  in  1  network input read strobe.
- net_rd_addr  in  clog2(N_IN)  network input read address.
- net_din  out  8 signed  network input data.
- net_ack_fill  in  1  network input load complete.
- net_req  out  1  start network compute.
- net_ack  in  1  network compute complete.
- net_out_valid  in  1 / net_out_data  in  8 signed  network output write.
- res_valid  out  1 / res_ready  in  1 / res_data  out  8 signed  host result stream.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when an inference completes.
- err  out  1  sticky timeout flag.

Function
REQ-005 SHALL implement states IDLE, NRST, LOAD, FILL, RUN, COLLECT, OUT, ERR.
REQ-006 IDLE: start=1 SHALL move to NRST and clear err; start is ignored in every other state.
REQ-007 NRST: net_rst SHALL be 1 for exactly 2 cycles, then the block moves to LOAD.
REQ-008 LOAD: in_ready SHALL be 1; each in_valid&in_ready beat SHALL write in_data to ibuf[icnt] and increment icnt; after beat N_IN the block moves to FILL. in_ready SHALL be 0 in every other state.
REQ-009 FILL: net_fill SHALL be 1; net_din SHALL equal ibuf[net_rd_addr] registered one cycle after net_rd; net_ack_fill=1 SHALL move to RUN with net_fill=0.
REQ-010 RUN: net_req SHALL be 1 until net_ack=1 is sampled, then the block moves to COLLECT.
REQ-011 net_out_valid SHALL be captured into obuf[ocnt] in RUN and COLLECT; ocnt saturates at N_OUT and excess beats are dropped.
REQ-012 COLLECT: when ocnt==N_OUT the block SHALL move to OUT.
REQ-013 OUT: res_valid=1 with res_data=obuf[rcnt]; each res_valid&res_ready SHALL advance rcnt; res_data SHALL be stable while res_ready=0; after beat N_OUT the block moves to IDLE with done=1 for one cycle.
REQ-014 A single timer SHALL clear on entry to FILL, RUN and COLLECT and increment each cycle in those states; reaching TMO SHALL move the block to ERR.
REQ-015 ERR: err=1, net_rst=1, all handshake outputs 0; the next cycle SHALL move to IDLE; err SHALL stay set until the next accepted start.
REQ-016 If net_ack and net_out_valid are both 1 in the same cycle in RUN, the output beat SHALL be captured.
REQ-017 icnt, ocnt and rcnt SHALL be clog2(N)+1 bits wide, compare for equality only, and never wrap.

Reset
REQ-018 While rst=1, state SHALL become IDLE, all counters and the timer SHALL be 0, and err, done, busy, in_ready, net_fill, net_req and res_valid SHALL be 0.
REQ-019 While rst=1, net_rst SHALL be 1.
REQ-020 rst SHALL abort any inference mid-operation; partial ibuf/obuf contents SHALL be discarded without an output beat.

Structure
REQ-021 The state encoding and the data width (8) SHALL live in shared package nn_pkg.
REQ-022 ibuf and obuf SHALL be one parameterised sub-module nn_seq_buf: registered read, single write port.
REQ-023 There SHALL be no combinational path from any net_* input to any host-side output.

Verification
REQ-024 Nominal: start; inputs 1,0; network model returns 1 → res_data=1, done 1 cycle, busy low afterwards.
REQ-025 Backpressure: hold res_ready=0 for 10 cycles → res_valid stays 1, res_data constant, accepted on release.
REQ-026 Timeout: network never asserts net_ack → err=1 after TMO cycles in RUN, net_rst pulses, state returns to IDLE.
REQ-027 Reset mid-FILL: assert rst → next cycle all outputs at reset values; a fresh start completes correctly.
REQ-028 Back-to-back: 4 inferences with inputs (0,0),(0,1),(1,0),(1,1) → results 0,1,1,0 in order.
REQ-029 Extra net_out_valid beat in COLLECT → it is dropped; exactly N_OUT results are delivered.
